slc3_control_unit: RTL

Instruction sequencing and decode unit for the SLC-3 processor. It is a Moore state machine that sits directly upstream of the SLC-3 datapath. It consumes the IR opcode fields and the branch-enable flag, and drives every load, gate, mux-select, ALU and memory-strobe control the datapath needs. It implements fetch, decode and execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE, with fixed-latency memory access.

---
 rtl/slc3_control_unit.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/slc3_control_unit.sv
// SLC-3 fetch/decode/execute sequencer: Moore FSM driving every datapath control.
// Define SLC3_PAUSE_EN to compile the PAUSE (opcode 1101) wait states and LD_LED.
module slc3_control_unit #(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, S18, S33, S35, S32, S01, S05, S09, S00, S22, S12, S20,
    S04, S21, S06, S25, S27, S07, S23, S16
`ifdef SLC3_PAUSE_EN
    , PAUSE_IR1, PAUSE_IR2
`endif
  } state_t;

  localparam logic [1:0] WAIT_LAST = 2'(MEM_WAIT - 1);

  state_t     state, state_next;
  logic [1:0] wait_cnt;
  logic       wait_last;
  logic       in_mem;

  // The S33/S25/S16 wait sequences share one state each plus a cycle counter.
  assign wait_last = (wait_cnt == WAIT_LAST);
  assign in_mem    = (state == S33) || (state == S25) || (state == S16);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= HALTED;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= (in_mem && !wait_last) ? wait_cnt + 2'd1 : '0;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      HALTED: if (Run) state_next = S18;
      S18:    state_next = S33;
      S33:    if (wait_last) state_next = S35;
      S35:    state_next = S32;
      S32: begin
        unique case (Opcode)
          4'b0001: state_next = S01;
          4'b0101: state_next = S05;
          4'b1001: state_next = S09;
          4'b0000: state_next = S00;
          4'b1100: state_next = S12;
          4'b0100: state_next = S04;
          4'b0110: state_next = S06;
          4'b0111: state_next = S07;
`ifdef SLC3_PAUSE_EN
          4'b1101: state_next = PAUSE_IR1;
`endif
          default: state_next = S18;
        endcase
      end
      S01, S05, S09, S12, S20, S22, S21, S27: state_next = S18;
      S00:    state_next = BEN ? S22 : S18;
      S04:    state_next = IR_11 ? S21 : S20;
      S06:    state_next = S25;
      S25:    if (wait_last) state_next = S27;
      S07:    state_next = S23;
      S23:    state_next = S16;
      S16:    if (wait_last) state_next = S18;
`ifdef SLC3_PAUSE_EN
      PAUSE_IR1: if (Continue) state_next = PAUSE_IR2;
      PAUSE_IR2: if (!Continue) state_next = S18;
`endif
      default: state_next = HALTED;
    endcase
  end

`ifndef SLC3_PAUSE_EN
  logic unused_continue;
  assign unused_continue = Continue;
`endif

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    unique case (state)
      S18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        PCMUX  = 2'b01;
        LD_PC  = 1'b1;
      end
      S33, S25: begin
        Mem_OE = 1'b1;
        LD_MDR = wait_last;
      end
      S35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S32: LD_BEN = 1'b1;
      S01, S05: begin
        SR1MUX  = 1'b1;
        SR2MUX  = IR_5;
        ALUK    = (state == S05) ? 2'b01 : 2'b00;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S09: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b10;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S22: begin
        ADDR2MUX = 2'b10;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S12, S20: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_PC   = 1'b1;
      end
      S04: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S21: begin
        ADDR2MUX = 2'b11;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S06, S07: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S27: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S23: begin
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S16: Mem_WE = 1'b1;
`ifdef SLC3_PAUSE_EN
      PAUSE_IR1: LD_LED = 1'b1;
`endif
      default: ;
    endcase
  end

endmodule
